pipe_scroller: RTL and testbench

//  Parametrised successor to the fixed 320-bit obstacle shifter in the game datapath. Holds an
//  N_COLS-entry scrolling playfield of pipes with LFSR-generated gap heights, and advances it on
//  a programmable tick. Checks bird height against column 0 for collision and counts passed pipes.

---
 rtl/pipe_scroller.sv | 139 +++++++++++++
 tb/tb_pipe_scroller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroller.sv
// Scrolling pipe playfield with LFSR gap generation, programmable step tick,
// bird collision check on column 0, pipe score and a registered read port.
module pipe_scroller #(
  parameter int          N_COLS       = 80,
  parameter int          H_W          = 7,
  parameter int          MAX_H        = 80,
  parameter int          GAP          = 20,
  parameter int          PIPE_SPACING = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         CW           = $clog2(N_COLS)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           run,
  input  logic [27:0]    tick_rate,
  input  logic [H_W-1:0] bird_h,
  input  logic [CW-1:0]  rd_col,
  output logic           rd_pipe,
  output logic [H_W-1:0] rd_gap_lo,
  output logic           step_pulse,
  output logic           collide,
  output logic           running,
  output logic [15:0]    score,
  output logic [1:0]     state_dbg
);

  localparam int             SW        = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  localparam logic [CW-1:0]  LAST_COL  = CW'(N_COLS - 1);
  localparam logic [SW-1:0]  SP_LAST   = SW'(PIPE_SPACING - 1);
  localparam logic [H_W:0]   GAP_RANGE = (H_W+1)'(MAX_H - GAP - 1);
  localparam logic [H_W:0]   GAP_SPAN  = (H_W+1)'(GAP - 1);
  localparam logic [H_W:0]   MAX_X     = (H_W+1)'(MAX_H);
  localparam logic [H_W:0]   ONE_X     = (H_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             col_pipe [N_COLS];
  logic [H_W-1:0]   col_gap  [N_COLS];
  logic [27:0]      tick_cnt;
  logic [SW-1:0]    spacing_cnt;
  logic [15:0]      lfsr;
  logic             step;
  logic             hit;
  logic [H_W:0]     bird_x;
  logic [H_W:0]     gap_x;
  logic [H_W-1:0]   gap_new;

  always_comb begin
    step    = (state == S_RUN) && run && (tick_cnt == 28'd0) && !start;
    bird_x  = {1'b0, bird_h};
    gap_x   = {1'b0, col_gap[0]};
    hit     = (bird_x == '0) || (bird_x >= MAX_X) ||
              (col_pipe[0] && ((bird_x < gap_x) || (bird_x > gap_x + GAP_SPAN)));
    // Folding by the range keeps every gap inside 1..MAX_H-GAP-1 for any LFSR value.
    gap_new = H_W'(({1'b0, lfsr[H_W-1:0]} % GAP_RANGE) + ONE_X);
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else begin
      unique case (state)
        S_RUN:   if (step) state_nxt = S_CHECK;
        S_CHECK: state_nxt = hit ? S_DEAD : S_RUN;
        default: state_nxt = state;
      endcase
    end
  end

  assign step_pulse = step;
  assign running    = (state == S_RUN) || (state == S_CHECK);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_COLS; i++) begin
        col_pipe[i] <= 1'b0;
        col_gap[i]  <= '0;
      end
      tick_cnt    <= '0;
      spacing_cnt <= '0;
      lfsr        <= LFSR_SEED;
      score       <= '0;
      collide     <= 1'b0;
      rd_pipe     <= 1'b0;
      rd_gap_lo   <= '0;
    end else begin
      if (rd_col <= LAST_COL) begin
        rd_pipe   <= col_pipe[rd_col];
        rd_gap_lo <= col_gap[rd_col];
      end else begin
        rd_pipe   <= 1'b0;
        rd_gap_lo <= '0;
      end

      if (start) begin
        for (int i = 0; i < N_COLS; i++) begin
          col_pipe[i] <= 1'b0;
          col_gap[i]  <= '0;
        end
        score       <= '0;
        collide     <= 1'b0;
        spacing_cnt <= '0;
        tick_cnt    <= tick_rate;
      end else begin
        if (step) begin
          for (int i = 0; i < N_COLS - 1; i++) begin
            col_pipe[i] <= col_pipe[i+1];
            col_gap[i]  <= col_gap[i+1];
          end
          col_pipe[N_COLS-1] <= (spacing_cnt == '0);
          col_gap[N_COLS-1]  <= (spacing_cnt == '0) ? gap_new : '0;
          spacing_cnt        <= (spacing_cnt == SP_LAST) ? '0 : spacing_cnt + 1'b1;
          lfsr               <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
          if (col_pipe[0] && (score != 16'hFFFF)) score <= score + 16'd1;
          tick_cnt           <= tick_rate;
        end else if (running && run && (tick_cnt != 28'd0)) begin
          // CHECK counts too, so a full period is tick_rate+1 cycles.
          tick_cnt <= tick_cnt - 28'd1;
        end
        if ((state == S_CHECK) && hit) collide <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomised games against a queue-based playfield model; a monitor pops one
// expected record per observed scroll step and checks timing, read port and score.
module tb_pipe_scroller;

  localparam int          N_COLS       = 80;
  localparam int          H_W          = 7;
  localparam int          MAX_H        = 80;
  localparam int          GAP          = 20;
  localparam int          PIPE_SPACING = 16;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  localparam int          G_MAX        = MAX_H - GAP - 1;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic           run = 1'b0;
  logic [27:0]    tick_rate = '0;
  logic [H_W-1:0] bird_h = '0;
  logic [6:0]     rd_col = '0;
  logic           rd_pipe;
  logic [H_W-1:0] rd_gap_lo;
  logic           step_pulse;
  logic           collide;
  logic           running;
  logic [15:0]    score;
  logic [1:0]     state_dbg;

  pipe_scroller dut (
    .clk(clk), .resetn(resetn), .start(start), .run(run), .tick_rate(tick_rate),
    .bird_h(bird_h), .rd_col(rd_col), .rd_pipe(rd_pipe), .rd_gap_lo(rd_gap_lo),
    .step_pulse(step_pulse), .collide(collide), .running(running), .score(score),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, simulation still running");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0]    cyc;
    logic           pre_pipe;
    logic [H_W-1:0] pre_gap;
    logic           new_pipe;
    logic [H_W-1:0] new_gap;
    logic [15:0]    score;
    logic           hit;
  } step_exp_t;
  localparam int EXP_W = $bits(step_exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: playfield as a queue, front = bird column
  logic [15:0] m_lfsr = LFSR_SEED;
  bit          m_pipe[$];
  int          m_gap[$];
  int          m_score;
  int          m_nsteps;

  function automatic logic [15:0] galois_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_start();
    m_pipe.delete();
    m_gap.delete();
    for (int i = 0; i < N_COLS; i++) begin
      m_pipe.push_back(1'b0);
      m_gap.push_back(0);
    end
    m_score  = 0;
    m_nsteps = 0;
  endtask

  task automatic model_step(output bit np, output int ng);
    int g;
    bit op;
    np = (m_nsteps % PIPE_SPACING) == 0;
    g  = 0;
    if (np) begin
      g = int'(m_lfsr[H_W-1:0]) + 1;
      while (g > G_MAX) g -= G_MAX;
    end
    ng       = g;
    m_lfsr   = galois_next(m_lfsr);
    m_nsteps++;
    op = m_pipe.pop_front();
    void'(m_gap.pop_front());
    if (op && m_score < 65535) m_score++;
    m_pipe.push_back(np);
    m_gap.push_back(g);
  endtask

  function automatic bit model_hit(input int b);
    int g;
    g = m_gap[0];
    return (b == 0) || (b >= MAX_H) || (m_pipe[0] && ((b < g) || (b > g + GAP - 1)));
  endfunction

  function automatic int pick_bird(input int kind, input bit make_hit);
    int g;
    int r;
    g = m_gap[0];
    if (!make_hit) begin
      if (!m_pipe[0]) return $urandom_range(1, MAX_H - 1);
      r = $urandom_range(0, 3);
      if (r == 0) return g;
      if (r == 1) return g + GAP - 1;
      return g + $urandom_range(0, GAP - 1);
    end
    case (kind)
      0:       return 0;
      1:       return MAX_H;
      2:       return m_pipe[0] ? g - 1 : 0;
      3:       return m_pipe[0] ? g + GAP : MAX_H;
      default: return $urandom_range(MAX_H, 127);
    endcase
  endfunction

  // monitor: one record per step, read port/score checked on the next two cycles
  step_exp_t c1, c2, me;
  bit c1_v = 1'b0;
  bit c2_v = 1'b0;

  always @(negedge clk) begin
    if (c2_v) begin
      check("rd_new_pipe", rd_pipe, c2.new_pipe);
      check("rd_new_gap", rd_gap_lo, c2.new_gap);
      check("collide_after_check", collide, c2.hit);
      check("running_after_check", running, !c2.hit);
      c2_v = 1'b0;
    end
    if (c1_v) begin
      check("rd_pre_step_pipe", rd_pipe, c1.pre_pipe);
      check("rd_pre_step_gap", rd_gap_lo, c1.pre_gap);
      check("score", score, c1.score);
      check("running_in_check", running, 1);
      c2   = c1;
      c2_v = 1'b1;
      c1_v = 1'b0;
    end
    if (step_pulse !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_step: step_pulse=%b at cycle %0d, expected no step", step_pulse, cyc);
      end else begin
        me = step_exp_t'(exp_q.pop_front());
        check("step_cycle", cyc, me.cyc);
        c1   = me;
        c1_v = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic play_game(input int rate, input int n_steps, input int hit_step,
                           input int hit_kind, input int pause_step, input int pause_len,
                           input bit do_reset);
    int c, next_step, steps, pause_from, ng, b;
    bit over, hit, run_now, np;
    step_exp_t e;
    if (rate == 0) pause_len = 0;
    rd_col     = 7'd79;
    tick_rate  = 28'(rate);
    start      = 1'b1;
    run        = 1'b1;
    pause_from = 0;
    model_start();
    next_step = int'(cyc) + rate + 1;
    next_cyc();
    start = 1'b0;
    steps = 0;
    over  = 1'b0;
    hit   = 1'b0;
    while (!over) begin
      c       = int'(cyc);
      run_now = !(pause_len > 0 && c >= pause_from && c < pause_from + pause_len);
      run     = run_now;
      if (!run_now) begin
        next_step++;
      end else if (c == next_step) begin
        e.cyc      = 32'(c);
        e.pre_pipe = m_pipe[N_COLS-1];
        e.pre_gap  = H_W'(m_gap[N_COLS-1]);
        model_step(np, ng);
        e.new_pipe = np;
        e.new_gap  = H_W'(ng);
        steps++;
        b      = pick_bird(hit_kind, steps == hit_step);
        hit    = model_hit(b);
        bird_h = H_W'(b);
        e.score = 16'(m_score);
        e.hit   = hit;
        exp_q.push_back(e);
        next_step = c + ((rate > 0) ? rate + 1 : 2);
        if (steps == pause_step) pause_from = c + 3;
        over = hit || (steps >= n_steps);
      end
      next_cyc();
    end
    if (hit) begin
      repeat (30) next_cyc();
    end else if (do_reset) begin
      next_cyc();
      next_cyc();
      #2 resetn = 1'b0;
      m_lfsr = LFSR_SEED;
      model_start();
      @(negedge clk);
      check("reset_score", score, 0);
      check("reset_collide", collide, 0);
      check("reset_running", running, 0);
      check("reset_step_pulse", step_pulse, 0);
      check("reset_state", state_dbg, 0);
      check("reset_rd_pipe", rd_pipe, 0);
      check("reset_rd_gap", rd_gap_lo, 0);
      next_cyc();
      run    = 1'b0;
      resetn = 1'b1;
      next_cyc();
    end else begin
      run = 1'b0;
      repeat (4) next_cyc();
    end
  endtask

  task automatic read_sweep(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rd_col = 7'(i);
      next_cyc();
      check("sweep_pipe", rd_pipe, (i < N_COLS) ? 32'(m_pipe[i]) : 32'd0);
      check("sweep_gap", rd_gap_lo, (i < N_COLS) ? 32'(m_gap[i]) : 32'd0);
    end
    rd_col = 7'd79;
    next_cyc();
  endtask

  task automatic start_and_check();
    run   = 1'b0;
    start = 1'b1;
    next_cyc();
    start = 1'b0;
    model_start();
    check("restart_collide", collide, 0);
    check("restart_running", running, 1);
    check("restart_score", score, 0);
    check("restart_state", state_dbg, 1);
    next_cyc();
  endtask

  // main sequence
  initial begin
    int r, n, hs, k, ps, pl;
    model_start();
    repeat (3) next_cyc();
    @(negedge clk);
    check("por_score", score, 0);
    check("por_collide", collide, 0);
    check("por_running", running, 0);
    check("por_step_pulse", step_pulse, 0);
    check("por_state", state_dbg, 0);
    check("por_rd_pipe", rd_pipe, 0);
    next_cyc();
    resetn = 1'b1;
    next_cyc();

    play_game(3, 97, 0, 0, 0, 0, 1'b0);
    read_sweep(0, 127);

    play_game($urandom_range(0, 2), 80, 80, 2, 0, 0, 1'b0);
    read_sweep(0, 127);
    start_and_check();

    play_game(1, 5, 1, 0, 0, 0, 1'b0);
    play_game(2, 5, 1, 1, 0, 0, 1'b0);
    play_game(0, 120, 96, 3, 0, 0, 1'b0);
    play_game(5, 6, 0, 0, 2, 50, 1'b0);
    rd_col = 7'd85;
    next_cyc();
    check("rd_out_of_range", rd_pipe, 0);
    rd_col = 7'd79;

    repeat (4) begin
      r  = $urandom_range(1, 4);
      n  = $urandom_range(20, 120);
      hs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      k  = $urandom_range(0, 4);
      ps = $urandom_range(1, n);
      pl = $urandom_range(1, 10);
      play_game(r, n, hs, k, ps, pl, 1'b0);
    end

    play_game(20, 3, 0, 0, 0, 0, 1'b1);
    read_sweep(0, 79);
    play_game(2, 20, 0, 0, 0, 0, 1'b0);

    repeat (4) next_cyc();
    check("leftover_steps", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
